guess_game_ctrl: RTL and testbench

GUESS_GAME_CTRL -- requirements
Module: guess_game_ctrl

---
 rtl/guess_game_ctrl.sv | 143 ++++++++++++++
 tb/tb_guess_game_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/guess_game_ctrl.sv
// guess_game_ctrl: turn-based number guessing game controller with
// per-player try counters, hints and win/lose tracking.
module guess_game_ctrl #(
  parameter int MAX_TRIES   = 10,
  parameter int NUM_PLAYERS = 2,
  parameter int PID_W       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic             guess_valid,
  input  logic [1:0]       comparison_result,
  output logic             start_random_gen,
  output logic [PID_W-1:0] cur_player,
  output logic [3:0]       tries_left,
  output logic             hint_up,
  output logic             hint_down,
  output logic [6:0]       game_status,
  output logic             game_over,
  output logic             winner_valid,
  output logic [PID_W-1:0] winner_id
);

  localparam int NSLOT = 2**PID_W;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    SEED = 3'b001,
    WAIT = 3'b010,
    WIN  = 3'b011,
    LOSE = 3'b100
  } state_t;

  state_t           state, state_n;
  logic [3:0]       cnt     [NSLOT];
  logic [3:0]       cnt_n   [NSLOT];
  logic [3:0]       dec_cnt [NSLOT];
  logic [PID_W-1:0] cur_n, win_id_n, nxt_pid;
  logic             mode_r, mode_n;
  logic             hu_n, hd_n, wv_n;
  logic             nxt_found, accept;

  assign accept = guess_valid && (comparison_result != 2'b11);

  // counters as they would be after a wrong guess (saturating at 0)
  always_comb begin
    for (int i = 0; i < NSLOT; i++) dec_cnt[i] = cnt[i];
    if (cnt[cur_player] != 4'd0)
      dec_cnt[cur_player] = cnt[cur_player] - 4'd1;
  end

  // first player after cur_player (wrapping, cur last) with tries left
  always_comb begin : next_player
    int idx;
    nxt_found = 1'b0;
    nxt_pid   = cur_player;
    idx       = 0;
    for (int k = 1; k <= NUM_PLAYERS; k++) begin
      idx = int'(cur_player) + k;
      if (idx >= NUM_PLAYERS) idx = idx - NUM_PLAYERS;
      if (!nxt_found && dec_cnt[idx[PID_W-1:0]] != 4'd0) begin
        nxt_found = 1'b1;
        nxt_pid   = idx[PID_W-1:0];
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    cur_n    = cur_player;
    mode_n   = mode_r;
    hu_n     = hint_up;
    hd_n     = hint_down;
    wv_n     = winner_valid;
    win_id_n = winner_id;
    if (start && state != SEED) begin
      state_n = SEED;
      for (int i = 0; i < NSLOT; i++) cnt_n[i] = 4'(MAX_TRIES);
      cur_n    = '0;
      mode_n   = mode;
      hu_n     = 1'b0;
      hd_n     = 1'b0;
      wv_n     = 1'b0;
      win_id_n = '0;
    end else begin
      unique case (state)
        SEED: state_n = WAIT;
        WAIT: begin
          if (accept) begin
            if (comparison_result == 2'b00) begin
              state_n  = WIN;
              wv_n     = 1'b1;
              win_id_n = cur_player;
              hu_n     = 1'b0;
              hd_n     = 1'b0;
            end else begin
              cnt_n = dec_cnt;
              hu_n  = (comparison_result == 2'b01);
              hd_n  = (comparison_result == 2'b10);
              if (mode_r) begin
                if (nxt_found) cur_n = nxt_pid;
                else state_n = LOSE;
              end else if (dec_cnt[0] == 4'd0) begin
                state_n = LOSE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      for (int i = 0; i < NSLOT; i++) cnt[i] <= 4'(MAX_TRIES);
      cur_player   <= '0;
      mode_r       <= 1'b0;
      hint_up      <= 1'b0;
      hint_down    <= 1'b0;
      winner_valid <= 1'b0;
      winner_id    <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      cur_player   <= cur_n;
      mode_r       <= mode_n;
      hint_up      <= hu_n;
      hint_down    <= hd_n;
      winner_valid <= wv_n;
      winner_id    <= win_id_n;
    end
  end

  assign start_random_gen = (state == SEED);
  assign tries_left       = cnt[cur_player];
  assign game_status      = {state, tries_left};
  assign game_over        = (state == WIN) || (state == LOSE);

endmodule

// File: tb/tb_guess_game_ctrl.sv
// tb_guess_game_ctrl: directed game scenarios plus random play,
// checked every cycle against a behavioural game model.
module tb_guess_game_ctrl;

  localparam int MT = 10;
  localparam int NP = 2;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          reset, start, mode, guess_valid;
  logic [1:0]    comparison_result;
  logic          start_random_gen, hint_up, hint_down;
  logic          game_over, winner_valid;
  logic [PW-1:0] cur_player, winner_id;
  logic [3:0]    tries_left;
  logic [6:0]    game_status;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  guess_game_ctrl #(
    .MAX_TRIES(MT), .NUM_PLAYERS(NP), .PID_W(PW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .guess_valid(guess_valid),
    .comparison_result(comparison_result),
    .start_random_gen(start_random_gen),
    .cur_player(cur_player), .tries_left(tries_left),
    .hint_up(hint_up), .hint_down(hint_down),
    .game_status(game_status), .game_over(game_over),
    .winner_valid(winner_valid), .winner_id(winner_id)
  );

  always #5 clk = ~clk;

  // game model: 0 idle, 1 seeding, 2 playing, 3 won, 4 lost
  int m_state;
  int m_cnt [NP];
  int m_cur, m_wid, m_mode;
  bit m_hu, m_hd, m_wv;

  always @(posedge clk) begin
    int nxt;
    bit found;
    if (!reset) begin
      m_state = 0;
      foreach (m_cnt[i]) m_cnt[i] = MT;
      m_cur = 0; m_wid = 0; m_mode = 0;
      m_hu = 0; m_hd = 0; m_wv = 0;
    end else if (start && m_state != 1) begin
      m_state = 1;
      foreach (m_cnt[i]) m_cnt[i] = MT;
      m_cur = 0; m_wid = 0; m_mode = int'(mode);
      m_hu = 0; m_hd = 0; m_wv = 0;
    end else if (m_state == 1) begin
      m_state = 2;
    end else if (m_state == 2 && guess_valid && comparison_result != 2'd3) begin
      if (comparison_result == 2'd0) begin
        m_state = 3; m_wv = 1; m_wid = m_cur; m_hu = 0; m_hd = 0;
      end else begin
        if (m_cnt[m_cur] > 0) m_cnt[m_cur] = m_cnt[m_cur] - 1;
        m_hu = (comparison_result == 2'd1);
        m_hd = (comparison_result == 2'd2);
        if (m_mode == 1) begin
          found = 0; nxt = m_cur;
          for (int k = 1; k <= NP; k++) begin
            if (!found && m_cnt[(m_cur + k) % NP] > 0) begin
              found = 1; nxt = (m_cur + k) % NP;
            end
          end
          if (found) m_cur = nxt;
          else m_state = 4;
        end else if (m_cnt[0] == 0) begin
          m_state = 4;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int t;
    if (cmp_en) begin
      t = m_cnt[m_cur];
      chk("srg", int'(start_random_gen), int'(m_state == 1));
      chk("cur_player", int'(cur_player), m_cur);
      chk("tries_left", int'(tries_left), t);
      chk("hint_up", int'(hint_up), int'(m_hu));
      chk("hint_down", int'(hint_down), int'(m_hd));
      chk("game_status", int'(game_status), m_state * 16 + t);
      chk("game_over", int'(game_over), int'(m_state == 3 || m_state == 4));
      chk("winner_valid", int'(winner_valid), int'(m_wv));
      chk("winner_id", int'(winner_id), m_wid);
    end
  end

  task automatic cyc(input logic r, input logic s, input logic md,
                     input logic gv, input logic [1:0] cr);
    reset = r; start = s; mode = md;
    guess_valid = gv; comparison_result = cr;
    @(negedge clk);
  endtask

  initial begin
    reset = 0; start = 0; mode = 0;
    guess_valid = 0; comparison_result = 2'd3;
    @(negedge clk);
    cyc(0, 0, 0, 0, 0);
    cmp_en = 1;
    chk("rst_status", int'(game_status), 7'b000_1010);
    chk("rst_tries", int'(tries_left), 10);
    chk("rst_srg", int'(start_random_gen), 0);
    chk("rst_over", int'(game_over), 0);

    cyc(1, 1, 0, 0, 0);
    chk("seed_pulse", int'(start_random_gen), 1);
    chk("seed_status", int'(game_status), 7'b001_1010);
    cyc(1, 0, 0, 0, 0);
    chk("seed_once", int'(start_random_gen), 0);
    chk("wait_status", int'(game_status), 7'b010_1010);

    for (int i = 1; i <= 10; i++) begin
      cyc(1, 0, 0, 1, 2'b01);
      chk("m0_tries", int'(tries_left), 10 - i);
    end
    chk("m0_lose_status", int'(game_status), 7'b100_0000);
    chk("m0_lose_over", int'(game_over), 1);
    repeat (3) cyc(1, 0, 0, 1, 2'b01);
    chk("m0_lose_hold", int'(game_status), 7'b100_0000);

    cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 2'b01);
    chk("m1_cur_a", int'(cur_player), 1);
    chk("m1_tries_a", int'(tries_left), 10);
    cyc(1, 0, 0, 1, 2'b10);
    chk("m1_cur_b", int'(cur_player), 0);
    chk("m1_hint_down", int'(hint_down), 1);
    cyc(1, 0, 0, 1, 2'b00);
    chk("m1_win_state", int'(game_status[6:4]), 3);
    chk("m1_win_id", int'(winner_id), 0);
    chk("m1_win_valid", int'(winner_valid), 1);
    chk("m1_win_tries", int'(tries_left), 9);

    cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    repeat (18) cyc(1, 0, 1, 1, 2'($urandom_range(1, 2)));
    chk("m1_last_try", int'(game_status), 7'b010_0001);
    cyc(1, 0, 1, 1, 2'b01);
    chk("m1_p0_out", int'(cur_player), 1);
    cyc(1, 0, 1, 1, 2'b11);
    chk("m1_no_result", int'(game_status), 7'b010_0001);
    cyc(1, 0, 1, 1, 2'b10);
    chk("m1_lose", int'(game_status), 7'b100_0000);

    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 2'b01);
    cyc(1, 1, 0, 1, 2'b00);
    chk("coll_status", int'(game_status), 7'b001_1010);
    chk("coll_wv", int'(winner_valid), 0);
    cyc(1, 0, 0, 0, 0);
    repeat (6) cyc(1, 0, 0, 1, 2'b10);
    chk("pre_rst_tries", int'(tries_left), 4);
    cyc(0, 0, 0, 0, 0);
    chk("mid_rst_status", int'(game_status), 7'b000_1010);
    chk("mid_rst_hint", int'(hint_down), 0);

    for (int n = 0; n < 4000; n++) begin
      cyc(logic'($urandom_range(0, 199) != 0),
          logic'($urandom_range(0, 24) == 0),
          logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 9) < 6),
          ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
